// File: rtl/axi_lite_master_cmd.sv
// Single-outstanding AXI-Lite initiator: one host command in, one AXI-Lite transaction out, one completion back.
// Optional byte strobes via `define AXIL_MST_WSTRB_EN (adds cmd_wstrb / m_axi_wstrb).
module axi_lite_master_cmd #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
`ifdef AXIL_MST_WSTRB_EN
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD      = 3'd3;
  localparam logic [2:0] RD_DATA = 3'd4;
  localparam logic [2:0] RSP     = 3'd5;

  logic [2:0]        state;
  logic              aw_done;
  logic              w_done;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        resp_q;
  logic              aw_hs;
  logic              w_hs;

  // Every valid/ready is decoded from registered state only, so no valid ever
  // depends combinationally on a ready from the slave.
  assign cmd_ready     = (state == IDLE);
  assign m_axi_awvalid = (state == WR) && !aw_done;
  assign m_axi_wvalid  = (state == WR) && !w_done;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD);
  assign m_axi_rready  = (state == RD_DATA);
  assign rsp_valid     = (state == RSP);

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_wdata  = wdata_q;
  assign rsp_write    = write_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_resp     = resp_q;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= cmd_write ? WR : RD;
          end
        end
        WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // AW and W may finish in either order or together.
          if ((aw_done || aw_hs) && (w_done || w_hs)) state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            resp_q  <= m_axi_bresp;
            rdata_q <= '0;
            state   <= RSP;
          end
        end
        RD: begin
          if (m_axi_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rdata_q <= m_axi_rdata;
            resp_q  <= m_axi_rresp;
            state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXIL_MST_WSTRB_EN
  logic [DATA_W/8-1:0] wstrb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstrb_q <= '0;
    end else if (state == IDLE && cmd_valid) begin
      wstrb_q <= cmd_wstrb;
    end
  end

  assign m_axi_wstrb = wstrb_q;
`else
  // Without strobes the slave treats every write as a full word.
`endif

endmodule

// File: tb/tb_axi_lite_master_cmd.sv
// Directed bench for axi_lite_master_cmd with a small AXI-Lite responder (regs 0x08/0x0C/0x10, DECERR elsewhere).
module tb_axi_lite_master_cmd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [31:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
`ifdef AXIL_MST_WSTRB_EN
  logic [3:0]  cmd_wstrb = 4'hF;
  logic [3:0]  m_axi_wstrb;
`endif

  int errors = 0;
  int checks = 0;

  // Responder controls
  int   w_stall = 0;
  logic b_hold = 1'b0;

  always #5 clk = ~clk;

  axi_lite_master_cmd #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
`ifdef AXIL_MST_WSTRB_EN
    .cmd_wstrb(cmd_wstrb), .m_axi_wstrb(m_axi_wstrb),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- responder model ----------------
  logic [31:0] reg08 = '0;
  logic [31:0] reg0c = '0;
  logic [31:0] reg10 = '0;
  logic        aw_got, w_got, b_pend;
  logic [31:0] aw_q, w_q;
  int          w_wait;

  function automatic logic [1:0] addrResp(input logic [31:0] a);
    return (a == 32'h08 || a == 32'h0C || a == 32'h10) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [31:0] readReg(input logic [31:0] a);
    case (a)
      32'h08:  return reg08;
      32'h0C:  return reg0c;
      32'h10:  return reg10;
      default: return 32'h0;
    endcase
  endfunction

  wire        aw_hs = m_axi_awvalid && m_axi_awready;
  wire        w_hs = m_axi_wvalid && m_axi_wready;
  wire        have_aw = aw_got || aw_hs;
  wire        have_w = w_got || w_hs;
  wire [31:0] aw_a = aw_hs ? m_axi_awaddr : aw_q;
  wire [31:0] w_d = w_hs ? m_axi_wdata : w_q;

  assign m_axi_awready = 1'b1;
  assign m_axi_arready = 1'b1;
  assign m_axi_wready  = (w_wait >= w_stall);

  // Register commit happens when both AW and W have arrived; B may be held back.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
      aw_q <= '0; w_q <= '0; w_wait <= 0;
      m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
      m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
    end else begin
      if (w_hs) w_wait <= 0;
      else if (m_axi_wvalid && !m_axi_wready) w_wait <= w_wait + 1;
      if (aw_hs) begin aw_got <= 1'b1; aw_q <= m_axi_awaddr; end
      if (w_hs) begin w_got <= 1'b1; w_q <= m_axi_wdata; end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (b_pend && !b_hold) begin m_axi_bvalid <= 1'b1; b_pend <= 1'b0; end
      if (have_aw && have_w) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        m_axi_bresp <= addrResp(aw_a);
        case (aw_a)
          32'h08: reg08 <= w_d;
          32'h0C: reg0c <= w_d;
          32'h10: reg10 <= w_d;
          default: ;
        endcase
        if (b_hold) b_pend <= 1'b1;
        else m_axi_bvalid <= 1'b1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rvalid <= 1'b1;
        m_axi_rdata  <= readReg(m_axi_araddr);
        m_axi_rresp  <= addrResp(m_axi_araddr);
      end else if (m_axi_rvalid && m_axi_rready) begin
        m_axi_rvalid <= 1'b0;
      end
    end
  end

  // Valid-cycle monitor for the stalled-write sequence
  logic mon_clear = 1'b0;
  int   aw_cyc, w_cyc, w_only_cyc;
  always @(posedge clk) begin
    if (mon_clear) begin
      aw_cyc <= 0; w_cyc <= 0; w_only_cyc <= 0;
    end else begin
      if (m_axi_awvalid) aw_cyc <= aw_cyc + 1;
      if (m_axi_wvalid) w_cyc <= w_cyc + 1;
      if (m_axi_wvalid && !m_axi_awvalid) w_only_cyc <= w_only_cyc + 1;
    end
  end

  // ---------------- tasks ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and returns the edge count from the accepting edge to rsp_valid.
  task automatic applyStimulus(input bit w, input logic [31:0] a, input logic [31:0] d, output int lat);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic consumeRsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [31:0] ctrlVec();
    return {25'b0, cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
            m_axi_bready, m_axi_rready, rsp_valid};
  endfunction

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int bad;
    vecs[0] = '{1'b1, 32'h08, 32'd4,       2'b00, 32'd0};
    vecs[1] = '{1'b1, 32'h0C, 32'd5,       2'b00, 32'd0};
    vecs[2] = '{1'b1, 32'h10, 32'd6,       2'b00, 32'd0};
    vecs[3] = '{1'b0, 32'h08, 32'hFFFF,    2'b00, 32'd4};
    vecs[4] = '{1'b0, 32'h0C, 32'hFFFF,    2'b00, 32'd5};
    vecs[5] = '{1'b0, 32'h10, 32'hFFFF,    2'b00, 32'd6};
    vecs[6] = '{1'b0, 32'h0A, 32'h0,       2'b11, 32'd0};
    vecs[7] = '{1'b1, 32'h14, 32'hDEAD,    2'b11, 32'd0};

    // Reset state, during and after reset
    #12;
    checkOutput("reset_ctrl", ctrlVec(), 32'h40);
    checkOutput("reset_rsp", {rsp_write, 27'b0, rsp_resp, 2'b0} | rsp_rdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("post_reset_ctrl", ctrlVec(), 32'h40);

    // Table-driven zero-wait transactions
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, lat);
      checkOutput($sformatf("v%0d_latency", i), lat, 32'd3);
      checkOutput($sformatf("v%0d_resp", i), {30'b0, rsp_resp}, {30'b0, vecs[i].resp});
      checkOutput($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].rdata);
      checkOutput($sformatf("v%0d_write", i), {31'b0, rsp_write}, {31'b0, vecs[i].write});
      consumeRsp();
    end

    // W held off 4 cycles after AW handshake
    $display("[TB] stalled W write");
    mon_clear = 1'b1;
    @(negedge clk);
    mon_clear = 1'b0;
    w_stall = 4;
    applyStimulus(1'b1, 32'h08, 32'd9, lat);
    w_stall = 0;
    checkOutput("stall_aw_cycles", aw_cyc, 32'd1);
    checkOutput("stall_w_cycles", w_cyc, 32'd5);
    checkOutput("stall_w_only_cycles", w_only_cyc, 32'd4);
    checkOutput("stall_latency", lat, 32'd7);
    checkOutput("stall_resp", {30'b0, rsp_resp}, 32'd0);
    consumeRsp();
    applyStimulus(1'b0, 32'h08, 32'h0, lat);
    checkOutput("stall_readback", rsp_rdata, 32'd9);
    consumeRsp();

    // Completion back-pressure with a competing command
    $display("[TB] response back-pressure");
    applyStimulus(1'b0, 32'h10, 32'h0, lat);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h08; cmd_wdata = 32'hFF;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ctrlVec() != 32'h01 || rsp_rdata != 32'd6 || rsp_resp != 2'b00) bad++;
    end
    checkOutput("bp_violations", bad, 32'd0);
    cmd_valid = 1'b0;
    consumeRsp();
    applyStimulus(1'b0, 32'h08, 32'h0, lat);
    checkOutput("bp_no_stray_write", rsp_rdata, 32'd9);
    consumeRsp();

    // Asynchronous reset while waiting in WR_RESP
    $display("[TB] reset in WR_RESP");
    b_hold = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0C; cmd_wdata = 32'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("in_wr_resp", ctrlVec(), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", ctrlVec(), 32'h40);
    checkOutput("async_reset_addr", m_axi_awaddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    b_hold = 1'b0;
    applyStimulus(1'b0, 32'h0C, 32'h0, lat);
    checkOutput("after_reset_latency", lat, 32'd3);
    checkOutput("after_reset_resp", {30'b0, rsp_resp}, 32'd0);
    checkOutput("after_reset_rdata", rsp_rdata, 32'd7);
    consumeRsp();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
